// File: rtl/alu_pkg.sv
// Shared ALU definitions: instruction constants, controller state encoding, default pipeline depth.
// Imported by the ALU and its issue controller so both agree on opcodes.
package alu_pkg;

    localparam logic [7:0] CLR_CMP_INS  = 8'h40;
    localparam logic [7:0] CMP_OFF_INS  = 8'h41;
    localparam logic [7:0] CMP_ON_INS   = 8'h42;
    localparam logic [7:0] SIGN_OFF_INS = 8'h43;
    localparam logic [7:0] SIGN_ON_INS  = 8'h44;

    localparam int ALU_LAT_DEF = 6;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MODE,
        ST_ISSUE,
        ST_WAIT,
        ST_CAPTURE,
        ST_RESP
    } alu_ctrl_state_t;

    function automatic logic is_mode_ins(input logic [7:0] i);
        return (i >= CMP_OFF_INS) && (i <= SIGN_ON_INS);
    endfunction

endpackage

// File: rtl/alu_flags.sv
// Architectural Z/C/V/N flag register with clear/load/hold; Z and N derived from the result byte.
// Latency: one edge from clr/load to flag outputs.
// Backpressure: none; clr has priority over load, otherwise flags hold.
module alu_flags (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       load,
    input  logic [7:0] res,
    input  logic       c_in,
    input  logic       v_in,
    output logic       zf,
    output logic       cf,
    output logic       vf,
    output logic       nf
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zf <= 1'b0;
            cf <= 1'b0;
            vf <= 1'b0;
            nf <= 1'b0;
        end else if (clr) begin
            zf <= 1'b0;
            cf <= 1'b0;
            vf <= 1'b0;
            nf <= 1'b0;
        end else if (load) begin
            zf <= (res == 8'h00);
            cf <= c_in;
            vf <= v_in;
            nf <= res[7];
        end
    end

endmodule

// File: rtl/alu_ctrl.sv
// Issue controller for the fixed-latency ALU: accepts one instruction, sequences the ALU, captures result/flags.
// Latency: ack at t, res_valid at t+ALU_LAT+2 (mode instructions: t+2); one op per ALU_LAT+3 cycles.
// Backpressure: req is only acked in IDLE; decode holds req until ack.
module alu_ctrl
    import alu_pkg::*;
#(
    parameter int ALU_LAT = ALU_LAT_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req,
    input  logic [7:0] ins,
    input  logic [7:0] op_a,
    input  logic [7:0] op_b,
    output logic       ack,
    output logic       busy,
    output logic [7:0] result,
    output logic       res_valid,
    output logic       zf,
    output logic       cf,
    output logic       vf,
    output logic       nf,
    output logic       alu_start,
    output logic [7:0] alu_cins,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    output logic       alu_oe,
    output logic       alu_carryin,
    input  logic [7:0] alu_out,
    input  logic       alu_carryout,
    input  logic       alu_overout,
    input  logic       alu_cmpo
);

    localparam int CNT_W = $clog2(ALU_LAT) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ALU_LAT - 1);

    alu_ctrl_state_t  state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             accept;
    logic             final_step;
    logic             pend_cmpo, pend_c, pend_v;
    logic             capture, flag_clr, flag_load;

    always_comb begin
        state_nxt  = state;
        accept     = 1'b0;
        final_step = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req) begin
                    accept    = 1'b1;
                    state_nxt = is_mode_ins(ins) ? ST_MODE : ST_ISSUE;
                end
            end
            ST_MODE:    state_nxt = ST_RESP;
            ST_ISSUE:   state_nxt = ST_WAIT;
            ST_WAIT: begin
                if (cnt == CNT_LAST) begin
                    final_step = 1'b1;
                    state_nxt  = ST_CAPTURE;
                end
            end
            ST_CAPTURE: state_nxt = ST_RESP;
            ST_RESP:    state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    // Same-cycle ack lets decode drop req on the accepting edge.
    assign ack = accept;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            alu_start <= 1'b0;
            alu_oe    <= 1'b0;
            res_valid <= 1'b0;
            alu_cins  <= 8'h00;
            alu_a     <= 8'h00;
            alu_b     <= 8'h00;
            cnt       <= '0;
            pend_cmpo <= 1'b0;
            pend_c    <= 1'b0;
            pend_v    <= 1'b0;
            result    <= 8'h00;
        end else begin
            state     <= state_nxt;
            busy      <= (state_nxt != ST_IDLE);
            alu_start <= (state_nxt == ST_ISSUE);
            alu_oe    <= (state_nxt == ST_CAPTURE);
            res_valid <= (state_nxt == ST_RESP);

            // Instruction byte is dropped back to 0x00 before RESP so no mode byte lingers.
            if (accept) begin
                alu_cins <= ins;
                alu_a    <= op_a;
                alu_b    <= op_b;
            end else if (state_nxt == ST_RESP || state_nxt == ST_IDLE) begin
                alu_cins <= 8'h00;
            end

            // cnt is 0 during the start cycle, so it reaches ALU_LAT-1 on the ALU's final step.
            if (accept)
                cnt <= '0;
            else if (state == ST_ISSUE || state == ST_WAIT)
                cnt <= cnt + 1'b1;

            if (final_step) begin
                pend_cmpo <= alu_cmpo;
                pend_c    <= alu_carryout;
                pend_v    <= alu_overout;
            end

            if (capture)
                result <= alu_out;
        end
    end

    assign capture   = (state == ST_CAPTURE);
    assign flag_clr  = capture && pend_cmpo && (alu_cins == CLR_CMP_INS);
    assign flag_load = capture && pend_cmpo && (alu_cins != CLR_CMP_INS);

    alu_flags u_flags (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (flag_clr),
        .load  (flag_load),
        .res   (alu_out),
        .c_in  (pend_c),
        .v_in  (pend_v),
        .zf    (zf),
        .cf    (cf),
        .vf    (vf),
        .nf    (nf)
    );

    assign alu_carryin = cf;

endmodule

// File: tb/tb_alu_ctrl.sv
// Bench for alu_ctrl: a stand-in ALU drives junk except on the final step / while oe is high,
// and a reference model tracks compare mode, result and flags from the instruction stream.
module tb_alu_ctrl;
    import alu_pkg::*;

    localparam int LAT = 6;
    localparam logic [7:0] ADD_INS = 8'h01;
    localparam logic [7:0] SUB_INS = 8'h02;

    typedef struct {
        logic [7:0] i;
        logic [7:0] a;
        logic [7:0] b;
    } op_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req = 1'b0;
    logic [7:0] ins = 8'h00, op_a = 8'h00, op_b = 8'h00;
    logic       ack, busy, res_valid, zf, cf, vf, nf;
    logic       alu_start, alu_oe, alu_carryin;
    logic [7:0] result, alu_cins, alu_a, alu_b;
    logic [7:0] alu_out = 8'h00;
    logic       alu_carryout = 1'b0, alu_overout = 1'b0, alu_cmpo = 1'b0;

    alu_ctrl #(.ALU_LAT(LAT)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req          (req),
        .ins          (ins),
        .op_a         (op_a),
        .op_b         (op_b),
        .ack          (ack),
        .busy         (busy),
        .result       (result),
        .res_valid    (res_valid),
        .zf           (zf),
        .cf           (cf),
        .vf           (vf),
        .nf           (nf),
        .alu_start    (alu_start),
        .alu_cins     (alu_cins),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_oe       (alu_oe),
        .alu_carryin  (alu_carryin),
        .alu_out      (alu_out),
        .alu_carryout (alu_carryout),
        .alu_overout  (alu_overout),
        .alu_cmpo     (alu_cmpo)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] alu_fn(input logic [7:0] i, input logic [7:0] a, input logic [7:0] b);
        return (i == SUB_INS) ? 8'(a - b) : 8'(a + b);
    endfunction

    // Stand-in ALU: cycles counted from the start cycle (0); real status only on step LAT-1.
    int         k = -1;
    logic       cmp_mode = 1'b0;
    logic       fin_c = 1'b0, fin_v = 1'b0;
    logic [1:0] rnd = 2'b00;

    always @(posedge clk) rnd <= 2'($urandom);

    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k        <= -1;
            cmp_mode <= 1'b0;
        end else begin
            if (alu_cins == CMP_ON_INS)
                cmp_mode <= 1'b1;
            else if (alu_cins == CMP_OFF_INS)
                cmp_mode <= 1'b0;
            if (alu_start)
                k <= 0;
            else if (k >= 0 && k < LAT)
                k <= k + 1;
            else
                k <= -1;
            if (!alu_start && k == LAT - 2) begin
                alu_cmpo     <= cmp_mode;
                alu_carryout <= rnd[0];
                alu_overout  <= rnd[1];
                fin_c        <= rnd[0];
                fin_v        <= rnd[1];
            end else begin
                alu_cmpo     <= 1'($urandom);
                alu_carryout <= 1'($urandom);
                alu_overout  <= 1'($urandom);
            end
            alu_out <= alu_oe ? alu_fn(alu_cins, alu_a, alu_b) : 8'($urandom);
        end
    end

    // Reference model state; exp_flags = {z, c, v, n}.
    logic [7:0] exp_res = 8'h00;
    logic [3:0] exp_flags = 4'h0;
    logic       ref_cmp = 1'b0;
    int         n_vec = 0;
    int         n_bad = 0;
    op_t        q[$];
    op_t        cur, done_op;
    logic [7:0] ins_tab [7] = '{ADD_INS, SUB_INS, CLR_CMP_INS, CMP_OFF_INS,
                                CMP_ON_INS, SIGN_OFF_INS, SIGN_ON_INS};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic ref_update(input logic [7:0] i, input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r;
        if (i == CMP_ON_INS)
            ref_cmp = 1'b1;
        else if (i == CMP_OFF_INS)
            ref_cmp = 1'b0;
        else if (i != SIGN_OFF_INS && i != SIGN_ON_INS) begin
            r = alu_fn(i, a, b);
            exp_res = r;
            if (ref_cmp)
                exp_flags = (i == CLR_CMP_INS) ? 4'h0 : {r == 8'h00, fin_c, fin_v, r[7]};
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ack"}, ack, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_start"}, alu_start, 0);
        chk({tag, "_oe"}, alu_oe, 0);
        chk({tag, "_rv"}, res_valid, 0);
        chk({tag, "_cins"}, alu_cins, 0);
        chk({tag, "_ab"}, {alu_a, alu_b}, 0);
        chk({tag, "_result"}, result, 0);
        chk({tag, "_flags"}, {zf, cf, vf, nf, alu_carryin}, 0);
    endtask

    task automatic do_op(input logic [7:0] i, input logic [7:0] a, input logic [7:0] b);
        logic md;
        int   last;
        md   = (i >= CMP_OFF_INS) && (i <= SIGN_ON_INS);
        last = md ? 2 : LAT + 2;
        @(negedge clk);
        req = 1'b1; ins = i; op_a = a; op_b = b;
        #1;
        chk("op_ack", ack, 1);
        chk("op_idle_busy", busy, 0);
        chk("op_idle_cins", alu_cins, 0);
        for (int c = 1; c <= last; c++) begin
            @(negedge clk);
            req = 1'b0; ins = 8'($urandom); op_a = 8'($urandom); op_b = 8'($urandom);
            #1;
            if (c == last)
                ref_update(i, a, b);
            chk("op_ack_low", ack, 0);
            chk("op_busy", busy, 1);
            chk("op_start", alu_start, !md && c == 1);
            chk("op_oe", alu_oe, !md && c == LAT + 1);
            chk("op_res_valid", res_valid, c == last);
            chk("op_cins", alu_cins, (c < last) ? i : 8'h00);
            if (!md && c < last)
                chk("op_ab", {alu_a, alu_b}, {a, b});
            chk("op_result", result, exp_res);
            chk("op_flags", {zf, cf, vf, nf}, exp_flags);
            chk("op_carryin", alu_carryin, exp_flags[2]);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        #1;
        chk_reset_vals("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Plain add, no compare mode: flags stay 0.
        do_op(ADD_INS, 8'h05, 8'h03);
        chk("add_result", result, 8'h08);
        // Compare on, equal subtract: Z=1, N=0.
        do_op(CMP_ON_INS, 8'h00, 8'h00);
        do_op(SUB_INS, 8'h10, 8'h10);
        chk("cmp_zn", {zf, nf}, 2'b10);
        do_op(CLR_CMP_INS, 8'h33, 8'h44);
        chk("clr_flags", {zf, cf, vf, nf}, 4'h0);
        do_op(SIGN_ON_INS, 8'h01, 8'h02);

        for (int n = 0; n < 12; n++)
            do_op(ins_tab[$urandom_range(0, 6)], 8'($urandom), 8'($urandom));

        // req held high: one accept every LAT+3 cycles.
        for (int c = 0; c < 3 * (LAT + 3); c++) begin
            @(negedge clk);
            if (c == 0 || c % (LAT + 3) == 1) begin
                cur.i = ($urandom_range(0, 1) == 1) ? ADD_INS : SUB_INS;
                cur.a = 8'($urandom);
                cur.b = 8'($urandom);
                req = 1'b1; ins = cur.i; op_a = cur.a; op_b = cur.b;
            end
            #1;
            chk("hold_ack", ack, c % (LAT + 3) == 0);
            chk("hold_start", alu_start, c % (LAT + 3) == 1);
            chk("hold_busy", busy, c % (LAT + 3) != 0);
            if (c % (LAT + 3) == 0)
                q.push_back(cur);
            else if (c % (LAT + 3) <= LAT + 1)
                chk("hold_cins", alu_cins, q[0].i);
            else begin
                done_op = q.pop_front();
                ref_update(done_op.i, done_op.a, done_op.b);
                chk("hold_res_valid", res_valid, 1);
                chk("hold_result", result, exp_res);
                chk("hold_flags", {zf, cf, vf, nf}, exp_flags);
            end
        end
        @(negedge clk);
        req = 1'b0;
        #1;
        chk("hold_release_ack", ack, 0);

        // Reset in the middle of an op, with flags set beforehand.
        do_op(CMP_ON_INS, 8'h00, 8'h00);
        do_op(SUB_INS, 8'h20, 8'h20);
        @(negedge clk);
        req = 1'b1; ins = ADD_INS; op_a = 8'h5A; op_b = 8'h11;
        #1;
        chk("rst_op_ack", ack, 1);
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            req = 1'b0;
            if (c == 4)
                rst_n = 1'b0;
        end
        #1;
        chk_reset_vals("midop_reset");
        exp_res = 8'h00;
        exp_flags = 4'h0;
        ref_cmp = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        do_op(ADD_INS, 8'h5A, 8'h11);
        chk("post_reset_result", result, 8'h6B);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
